// File: rtl/prim_pad_wrapper_pkg.sv
// Pad type enumeration shared by the pad wrappers and their attribute logic.
// Only BidirStd pads accept attribute writes; every other type reads as zero.
package prim_pad_wrapper_pkg;

    typedef enum logic [2:0] {
        BidirStd,
        BidirTol,
        BidirOd,
        InputStd,
        AnalogIn0,
        AnalogIn1
    } pad_type_e;

endpackage

// File: rtl/pinmux_pad_attr_seq.sv
// Per-pad attribute registers with a glitch-free update sequencer.
// A changed write gates the pad's output enable low, waits SettleCycles,
// applies the new value, then releases the gate and responds.
// Ports: clk_i/rst_ni (async low); host req_i/we_i/addr_i/wdata_i,
// gnt_o/rvalid_o/rdata_o; busy_o; attr_o (pad i at [i*AttrW +: AttrW]);
// oe_gate_o (1 = output enable permitted).
// Option: define PINMUX_ATTR_LOCK_EN to make bit AttrW-1 a sticky lock.
module pinmux_pad_attr_seq
    import prim_pad_wrapper_pkg::*;
#(
    parameter int          NumPads      = 4,
    parameter int          AttrW        = 8,
    parameter pad_type_e   PadType      = BidirStd,
    parameter logic [AttrW-1:0] WarlMask  = 8'hFF,
    parameter logic [AttrW-1:0] ResetAttr = 8'h00,
    parameter int          SettleCycles = 2,
    localparam int         AW = $clog2(NumPads > 2 ? NumPads : 2)
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     req_i,
    input  logic                     we_i,
    input  logic [AW-1:0]            addr_i,
    input  logic [AttrW-1:0]         wdata_i,
    output logic                     gnt_o,
    output logic                     rvalid_o,
    output logic [AttrW-1:0]         rdata_o,
    output logic                     busy_o,
    output logic [NumPads*AttrW-1:0] attr_o,
    output logic [NumPads-1:0]       oe_gate_o
);

    localparam logic [AttrW-1:0] EffMask =
        (PadType == BidirStd) ? WarlMask : '0;
    localparam int CW = (SettleCycles > 0) ? $clog2(SettleCycles + 1) : 1;
    localparam int SettleInit = (SettleCycles > 0) ? SettleCycles - 1 : 0;

    typedef enum logic [2:0] {
        Idle,
        Gate,
        Settle,
        Apply,
        Release
    } state_e;

    state_e stateQ, stateD;
    logic [CW-1:0]    cntQ, cntD;
    logic [AW-1:0]    padSelQ;
    logic [AttrW-1:0] newValQ;
    logic [AttrW-1:0] attrQ [NumPads];
    logic             rvalidQ;
    logic [AttrW-1:0] rdataQ;

    logic             inRange;
    logic [AttrW-1:0] curAttr;
    logic [AttrW-1:0] legal;
    logic             locked;
    logic             startSeq;
    logic             gateLow;

    assign inRange = 32'(addr_i) < 32'(NumPads);
    assign curAttr = inRange ? attrQ[addr_i] : '0;
    assign legal   = wdata_i & EffMask;

`ifdef PINMUX_ATTR_LOCK_EN
    assign locked = curAttr[AttrW-1];
`else
    assign locked = 1'b0;
`endif

    assign gnt_o    = req_i & (stateQ == Idle);
    assign startSeq = gnt_o & we_i & inRange & ~locked & (legal != curAttr);
    assign busy_o   = (stateQ != Idle);

    // Release reports the freshly applied value; everything else is the
    // registered single-cycle response captured at grant.
    assign rvalid_o = rvalidQ | (stateQ == Release);
    assign rdata_o  = (stateQ == Release) ? attrQ[padSelQ] : rdataQ;

    assign gateLow = (stateQ == Gate) | (stateQ == Settle) | (stateQ == Apply);

    for (genvar i = 0; i < NumPads; i++) begin : gPad
        assign attr_o[i*AttrW +: AttrW] = attrQ[i];
        assign oe_gate_o[i] = ~(gateLow & (padSelQ == AW'(i)));
    end

    always_comb begin
        stateD = stateQ;
        cntD   = cntQ;
        unique case (stateQ)
            Idle: begin
                if (startSeq) stateD = Gate;
            end
            Gate: begin
                if (SettleCycles == 0) begin
                    stateD = Apply;
                end else begin
                    stateD = Settle;
                    cntD   = CW'(SettleInit);
                end
            end
            Settle: begin
                if (cntQ == '0) stateD = Apply;
                else            cntD   = cntQ - 1'b1;
            end
            Apply:   stateD = Release;
            Release: stateD = Idle;
            default: stateD = Idle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stateQ  <= Idle;
            cntQ    <= '0;
            padSelQ <= '0;
            newValQ <= '0;
            rvalidQ <= 1'b0;
            rdataQ  <= '0;
            for (int i = 0; i < NumPads; i++) begin
                attrQ[i] <= ResetAttr & EffMask;
            end
        end else begin
            stateQ  <= stateD;
            cntQ    <= cntD;
            rvalidQ <= gnt_o & ~startSeq;
            if (gnt_o) rdataQ <= curAttr;
            if (startSeq) begin
                padSelQ <= addr_i;
                newValQ <= legal;
            end
            if (stateQ == Apply) attrQ[padSelQ] <= newValQ;
        end
    end

endmodule

// File: tb/tb_pinmux_pad_attr_seq.sv
// Directed bench for pinmux_pad_attr_seq: a BidirStd instance and a
// read-only pad type instance, checked with immediate assertions.
module tb_pinmux_pad_attr_seq;
    import prim_pad_wrapper_pkg::*;

    logic        clk = 1'b0;
    logic        rstN;
    logic        req, we;
    logic [1:0]  addr;
    logic [7:0]  wdata;
    logic        gnt, rvalid, busy;
    logic [7:0]  rdata;
    logic [31:0] attr;
    logic [3:0]  oeGate;

    logic        req1, we1;
    logic [1:0]  addr1;
    logic [7:0]  wdata1;
    logic        gnt1, rvalid1, busy1;
    logic [7:0]  rdata1;
    logic [31:0] attr1;
    logic [3:0]  oeGate1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pinmux_pad_attr_seq dut (
        .clk_i(clk), .rst_ni(rstN),
        .req_i(req), .we_i(we), .addr_i(addr), .wdata_i(wdata),
        .gnt_o(gnt), .rvalid_o(rvalid), .rdata_o(rdata), .busy_o(busy),
        .attr_o(attr), .oe_gate_o(oeGate)
    );

    pinmux_pad_attr_seq #(.PadType(InputStd)) dutRo (
        .clk_i(clk), .rst_ni(rstN),
        .req_i(req1), .we_i(we1), .addr_i(addr1), .wdata_i(wdata1),
        .gnt_o(gnt1), .rvalid_o(rvalid1), .rdata_o(rdata1), .busy_o(busy1),
        .attr_o(attr1), .oe_gate_o(oeGate1)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue a write at the current cycle (cycle 0), check grant, move to
    // cycle 1 with the request dropped.
    task automatic doWrite(input string tag, input logic [1:0] a,
                           input logic [7:0] d);
        req = 1'b1; we = 1'b1; addr = a; wdata = d;
        #1;
        check({tag, "_gnt"}, gnt, 1);
        check({tag, "_noRvalidAtGnt"}, rvalid, 0);
        step();
        req = 1'b0;
    endtask

    task automatic waitResp(input string tag, input logic [7:0] exp);
        int n = 0;
        while (!rvalid && n < 20) begin
            step();
            n++;
        end
        check({tag, "_rvalid"}, rvalid, 1);
        check({tag, "_rdata"}, rdata, exp);
    endtask

    initial begin
        rstN = 1'b0;
        req = 0; we = 0; addr = 0; wdata = 0;
        req1 = 0; we1 = 0; addr1 = 0; wdata1 = 0;
        #12;
        check("rst_attr", attr, 32'h0);
        check("rst_oe", oeGate, 4'hF);
        check("rst_busy", busy, 0);
        check("rst_rvalid", rvalid, 0);
        check("rst_rdata", rdata, 0);
        #10 rstN = 1'b1;
        step();

        // Changed write to pad 2: gate low cycles 1..4, apply at 5.
        doWrite("w2", 2'd2, 8'h5A);
        for (int c = 1; c <= 4; c++) begin
            check($sformatf("w2_oe_c%0d", c), oeGate, 4'b1011);
            check($sformatf("w2_busy_c%0d", c), busy, 1);
            check($sformatf("w2_rv_c%0d", c), rvalid, 0);
            check($sformatf("w2_attr_c%0d", c), attr, 32'h0);
            step();
        end
        check("w2_rvalid_c5", rvalid, 1);
        check("w2_rdata_c5", rdata, 8'h5A);
        check("w2_attr_c5", attr, 32'h005A_0000);
        check("w2_oe_c5", oeGate, 4'hF);
        step();
        check("w2_idle_busy", busy, 0);
        check("w2_idle_rvalid", rvalid, 0);

        // Same value again: immediate response, no gating.
        doWrite("rw2", 2'd2, 8'h5A);
        check("rw2_rvalid", rvalid, 1);
        check("rw2_rdata", rdata, 8'h5A);
        check("rw2_oe", oeGate, 4'hF);
        check("rw2_busy", busy, 0);
        step();

        // Write pad 1 then a held read of pad 1.
        doWrite("w1", 2'd1, 8'h3C);
        req = 1'b1; we = 1'b0; addr = 2'd1;
        for (int c = 1; c <= 4; c++) begin
            #1;
            check($sformatf("rd_held_c%0d", c), gnt, 0);
            check($sformatf("w1_oe_c%0d", c), oeGate, 4'b1101);
            step();
        end
        #1;
        check("rd_held_c5", gnt, 0);
        check("w1_rvalid_c5", rvalid, 1);
        check("w1_rdata_c5", rdata, 8'h3C);
        step();
        #1;
        check("rd_gnt_c6", gnt, 1);
        step();
        req = 1'b0;
        check("rd_rvalid", rvalid, 1);
        check("rd_rdata", rdata, 8'h3C);
        check("rd_attr", attr, 32'h005A_3C00);
        step();

        // Read-only pad type: write is legalised to zero.
        req1 = 1'b1; we1 = 1'b1; addr1 = 2'd0; wdata1 = 8'hFF;
        #1;
        check("ro_gnt", gnt1, 1);
        step();
        req1 = 1'b0;
        check("ro_rvalid", rvalid1, 1);
        check("ro_rdata", rdata1, 8'h00);
        check("ro_busy", busy1, 0);
        check("ro_oe", oeGate1, 4'hF);
        check("ro_attr", attr1, 32'h0);
        step();

        // Top-bit handling on pad 3.
        doWrite("w3a", 2'd3, 8'h81);
        waitResp("w3a", 8'h81);
        step();
        check("w3a_attr", attr, 32'h815A_3C00);
        doWrite("w3b", 2'd3, 8'h02);
`ifdef PINMUX_ATTR_LOCK_EN
        check("lock_rvalid", rvalid, 1);
        check("lock_rdata", rdata, 8'h81);
        check("lock_busy", busy, 0);
        check("lock_oe", oeGate, 4'hF);
        step();
        check("lock_attr", attr, 32'h815A_3C00);
`else
        check("w3b_oe", oeGate, 4'b0111);
        waitResp("w3b", 8'h02);
        step();
        check("w3b_attr", attr, 32'h025A_3C00);
`endif

        // Asynchronous reset during SETTLE.
        doWrite("wr0", 2'd0, 8'h77);
        step();
        check("wr0_oe_settle", oeGate, 4'b1110);
        check("wr0_busy_settle", busy, 1);
        rstN = 1'b0;
        #1;
        check("arst_attr", attr, 32'h0);
        check("arst_oe", oeGate, 4'hF);
        check("arst_busy", busy, 0);
        check("arst_rvalid", rvalid, 0);
        check("arst_rdata", rdata, 0);
        #10 rstN = 1'b1;
        for (int c = 0; c < 6; c++) begin
            step();
            check($sformatf("arst_norv_c%0d", c), rvalid, 0);
        end
        check("arst_attr_after", attr, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
